// File: rtl/cpu_instr_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_instr_sequencer
//
// Instruction feeder for the cpu datapath/controller. It holds a small program
// in word memory, walks a program counter, and hands each word to the cpu.
// The cpu sees the word on `in` with a one-cycle `load` strobe, and is then
// started with `s`. The cpu's `w` (waiting) flag paces each instruction.
// A program ends on a HALT word, or after the last memory address has executed.
//
// State table
//   state | meaning
//   IDLE  | after reset; program writes accepted; waits for go
//   FETCH | memory word at pc read into in/halt registers
//   LOAD  | load=1 with the instruction on in (skipped strobe on HALT)
//   START | s=1 until the cpu drops w (it has begun executing)
//   EXEC  | waits for the cpu to raise w again (instruction finished)
//   DONE  | program finished; pc/in/issued held; writes and go accepted
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset (memory contents are kept)
//   prog_we    program write strobe, honoured only in IDLE/DONE
//   prog_addr  program write address
//   prog_data  program write data
//   go         start request, sampled in IDLE/DONE
//   w          cpu waiting flag
//   in         instruction to cpu (registered)
//   load       cpu instruction-register load strobe (registered)
//   s          cpu start strobe (registered)
//   pc         address of the instruction being fetched or executed
//   busy       high in every state except IDLE and DONE
//   done       high in DONE
//   issued     instructions issued since the last go, saturating at 255
// -----------------------------------------------------------------------------
module cpu_instr_sequencer #(
   parameter int unsigned ADDR_W  = 5,
   parameter logic [2:0]  HALT_OP = 3'b111
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              prog_we,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [15:0]       prog_data,
   input  logic              go,
   input  logic              w,
   output logic [15:0]       in,
   output logic              load,
   output logic              s,
   output logic [ADDR_W-1:0] pc,
   output logic              busy,
   output logic              done,
   output logic [7:0]        issued
);

   localparam int unsigned       DEPTH   = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] PC_LAST = {ADDR_W{1'b1}};

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_LOAD,
      ST_START,
      ST_EXEC,
      ST_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [15:0]       in_q, in_d;
   logic              load_q, load_d;
   logic              s_q, s_d;
   logic              halt_q, halt_d;
   logic [7:0]        issued_q, issued_d;

   logic [15:0]       mem [DEPTH];
   logic [15:0]       rd_word;
   logic              rd_halt;
   logic              mem_we;

   // Program memory has no reset, so a system reset leaves the program intact.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[prog_addr] <= prog_data;
      end
   end

   // The word at pc is captured into in_q/halt_q on the FETCH edge. That
   // capture is the synchronous read, so the word is valid during LOAD.
   assign rd_word = mem[pc_q];
   assign rd_halt = (rd_word[15:13] == HALT_OP);

   // State register and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         pc_q     <= '0;
         in_q     <= '0;
         load_q   <= 1'b0;
         s_q      <= 1'b0;
         halt_q   <= 1'b0;
         issued_q <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         in_q     <= in_d;
         load_q   <= load_d;
         s_q      <= s_d;
         halt_q   <= halt_d;
         issued_q <= issued_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE,
         ST_DONE:  if (go) state_d = ST_FETCH;
         ST_FETCH: state_d = ST_LOAD;
         ST_LOAD:  state_d = halt_q ? ST_DONE : ST_START;
         ST_START: if (!w) state_d = ST_EXEC;
         ST_EXEC:  if (w)  state_d = (pc_q == PC_LAST) ? ST_DONE : ST_FETCH;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Output and datapath logic. load/s are registered, so they are derived
   // from the state being entered. This makes load high exactly in LOAD and
   // s high exactly in START.
   always_comb begin
      pc_d     = pc_q;
      in_d     = in_q;
      halt_d   = halt_q;
      issued_d = issued_q;
      load_d   = 1'b0;
      s_d      = (state_d == ST_START);
      busy     = (state_q != ST_IDLE) && (state_q != ST_DONE);
      done     = (state_q == ST_DONE);
      mem_we   = prog_we && !busy;

      case (state_q)
         ST_IDLE,
         ST_DONE: begin
            if (go) begin
               pc_d     = '0;
               issued_d = '0;
            end
         end
         ST_FETCH: begin
            // A HALT word never reaches the cpu: in keeps the last instruction.
            halt_d = rd_halt;
            if (!rd_halt) begin
               in_d   = rd_word;
               load_d = 1'b1;
            end
         end
         ST_START: begin
            if (!w && (issued_q != 8'hFF)) begin
               issued_d = issued_q + 8'd1;
            end
         end
         ST_EXEC: begin
            // At the last address pc is held so DONE reports where it stopped.
            if (w && (pc_q != PC_LAST)) begin
               pc_d = pc_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign in     = in_q;
   assign load   = load_q;
   assign s      = s_q;
   assign pc     = pc_q;
   assign issued = issued_q;

endmodule

// File: tb/tb_cpu_instr_sequencer.sv
module tb_cpu_instr_sequencer;

   localparam int ADDR_W = 5;

   logic              clk       = 1'b0;
   logic              reset     = 1'b0;
   logic              prog_we   = 1'b0;
   logic [ADDR_W-1:0] prog_addr = '0;
   logic [15:0]       prog_data = '0;
   logic              go        = 1'b0;
   logic              w         = 1'b1;
   logic [15:0]       in;
   logic              load;
   logic              s;
   logic [ADDR_W-1:0] pc;
   logic              busy;
   logic              done;
   logic [7:0]        issued;

   int errors = 0;
   int checks = 0;

   // Behavioural cpu: registers, flags and the w handshake.
   logic [15:0] regs [8];
   logic [15:0] ir = '0;
   logic        flag_n = 1'b0, flag_z = 1'b0, flag_v = 1'b0;
   int          cpu_phase = 0;
   int          cpu_cnt   = 0;
   int          load_cnt  = 0;
   int          start_dly = 1;
   int          exec_lat  = 3;

   cpu_instr_sequencer #(.ADDR_W(ADDR_W), .HALT_OP(3'b111)) dut (
      .clk       (clk),
      .reset     (reset),
      .prog_we   (prog_we),
      .prog_addr (prog_addr),
      .prog_data (prog_data),
      .go        (go),
      .w         (w),
      .in        (in),
      .load      (load),
      .s         (s),
      .pc        (pc),
      .busy      (busy),
      .done      (done),
      .issued    (issued)
   );

   always #5 clk = ~clk;

   task automatic cpu_execute(input logic [15:0] i);
      logic [15:0] a, b, r;
      a = regs[i[10:8]];
      b = regs[i[2:0]];
      case (i[4:3])
         2'b01:   b = b << 1;
         2'b10:   b = b >> 1;
         2'b11:   b = {b[15], b[15:1]};
         default: ;
      endcase
      case (i[15:11])
         5'b11010: regs[i[10:8]] = {{8{i[7]}}, i[7:0]};
         5'b11000: regs[i[7:5]]  = b;
         5'b10100: regs[i[7:5]]  = a + b;
         5'b10101: begin
            r      = a - b;
            flag_z = (r == 16'h0000);
            flag_n = r[15];
            flag_v = (a[15] != b[15]) && (r[15] != a[15]);
         end
         5'b10110: regs[i[7:5]]  = a & b;
         5'b10111: regs[i[7:5]]  = ~b;
         default: ;
      endcase
   endtask

   // The cpu drops w start_dly cycles after seeing s, executes for exec_lat
   // cycles, then raises w again. It is reset by the same system reset.
   always @(negedge clk or negedge reset) begin
      if (!reset) begin
         w         = 1'b1;
         cpu_phase = 0;
         cpu_cnt   = 0;
      end else begin
         if (load) begin
            ir = in;
            load_cnt++;
         end
         case (cpu_phase)
            0: if (s) begin cpu_cnt = start_dly; cpu_phase = 1; end
            1: if (cpu_cnt <= 1) begin w = 1'b0; cpu_cnt = exec_lat; cpu_phase = 2; end
               else cpu_cnt--;
            2: if (cpu_cnt <= 1) begin cpu_execute(ir); w = 1'b1; cpu_phase = 0; end
               else cpu_cnt--;
            default: cpu_phase = 0;
         endcase
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic write_word(input logic [ADDR_W-1:0] a, input logic [15:0] d);
      prog_we   = 1'b1;
      prog_addr = a;
      prog_data = d;
      tick();
      prog_we   = 1'b0;
   endtask

   task automatic pulse_go();
      go = 1'b1;
      tick();
      go = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      int n = 0;
      while (!done && n < budget) begin
         tick();
         n++;
      end
      ok = done;
   endtask

   task automatic clear_regs();
      for (int i = 0; i < 8; i++) regs[i] = 16'h0000;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      tick(3);
      checks++; if (in !== 16'h0000) begin errors++; $display("FAIL rst_in: got %h want 0000", in); end
      checks++; if (load !== 1'b0)   begin errors++; $display("FAIL rst_load: got %b want 0", load); end
      checks++; if (s !== 1'b0)      begin errors++; $display("FAIL rst_s: got %b want 0", s); end
      checks++; if (pc !== 5'd0)     begin errors++; $display("FAIL rst_pc: got %0d want 0", pc); end
      checks++; if (busy !== 1'b0 || done !== 1'b0)
         begin errors++; $display("FAIL rst_busy_done: got %b%b want 00", busy, done); end
      checks++; if (issued !== 8'd0) begin errors++; $display("FAIL rst_issued: got %0d want 0", issued); end
      reset = 1'b1;
      tick(3);
      checks++; if ({busy, done, load, s} !== 4'b0000)
         begin errors++; $display("FAIL idle_flags: busy/done/load/s=%b want 0000", {busy, done, load, s}); end
      checks++; if (in !== 16'h0000) begin errors++; $display("FAIL idle_in: got %h want 0000", in); end
   endtask

   task automatic test_single_mov();
      bit ok;
      clear_regs();
      load_cnt = 0;
      write_word(5'd0, 16'hD003);
      // Write and start in the same cycle: both must take effect.
      prog_we = 1'b1; prog_addr = 5'd1; prog_data = 16'hE000; go = 1'b1;
      tick();
      prog_we = 1'b0; go = 1'b0;
      checks++; if ({busy, load, s} !== 3'b100)
         begin errors++; $display("FAIL fetch_cycle: busy/load/s=%b want 100", {busy, load, s}); end
      tick();
      checks++; if (load !== 1'b1 || in !== 16'hD003 || s !== 1'b0)
         begin errors++; $display("FAIL load_cycle: load=%b in=%h s=%b want 1 D003 0", load, in, s); end
      tick();
      checks++; if (s !== 1'b1 || load !== 1'b0)
         begin errors++; $display("FAIL start_cycle: s=%b load=%b want 1 0", s, load); end
      tick();
      checks++; if (s !== 1'b1 || w !== 1'b0)
         begin errors++; $display("FAIL start_hold: s=%b w=%b want 1 0", s, w); end
      tick();
      checks++; if (s !== 1'b0 || issued !== 8'd1)
         begin errors++; $display("FAIL exec_enter: s=%b issued=%0d want 0 1", s, issued); end
      wait_done(100, ok);
      checks++; if (!ok) begin errors++; $display("FAIL single_done: done=%b want 1", done); end
      checks++; if (issued !== 8'd1 || pc !== 5'd1)
         begin errors++; $display("FAIL single_end: issued=%0d pc=%0d want 1 1", issued, pc); end
      checks++; if (in !== 16'hD003 || load_cnt !== 1)
         begin errors++; $display("FAIL single_in: in=%h loads=%0d want D003 1", in, load_cnt); end
      checks++; if (regs[0] !== 16'h0003) begin errors++; $display("FAIL single_r0: got %h want 0003", regs[0]); end
   endtask

   task automatic test_program();
      bit ok;
      clear_regs();
      load_cnt = 0;
      write_word(5'd0, 16'hD003); // MOV R0,#3
      write_word(5'd1, 16'hD104); // MOV R1,#4
      write_word(5'd2, 16'hA081); // ADD R4,R0,R1
      write_word(5'd3, 16'hA801); // CMP R0,R1
      write_word(5'd4, 16'hB8C0); // MVN R6,R0
      write_word(5'd5, 16'hE000); // HALT
      pulse_go();
      wait_done(200, ok);
      checks++; if (!ok) begin errors++; $display("FAIL prog_done: done=%b want 1", done); end
      checks++; if (regs[4] !== 16'h0007) begin errors++; $display("FAIL prog_r4: got %h want 0007", regs[4]); end
      checks++; if (regs[6] !== 16'hFFFC) begin errors++; $display("FAIL prog_r6: got %h want FFFC", regs[6]); end
      checks++; if ({flag_n, flag_z, flag_v} !== 3'b100)
         begin errors++; $display("FAIL prog_flags: NZV=%b want 100", {flag_n, flag_z, flag_v}); end
      checks++; if (issued !== 8'd5 || pc !== 5'd5 || load_cnt !== 5)
         begin errors++; $display("FAIL prog_count: issued=%0d pc=%0d loads=%0d want 5 5 5", issued, pc, load_cnt); end
   endtask

   task automatic test_wrap_end();
      bit ok;
      for (int i = 0; i < 32; i++) write_word(5'(i), 16'hD001);
      load_cnt = 0;
      pulse_go();
      wait_done(600, ok);
      checks++; if (!ok) begin errors++; $display("FAIL wrap_done: done=%b want 1", done); end
      checks++; if (issued !== 8'd32 || pc !== 5'd31)
         begin errors++; $display("FAIL wrap_end: issued=%0d pc=%0d want 32 31", issued, pc); end
      tick(10);
      checks++; if (load_cnt !== 32 || done !== 1'b1)
         begin errors++; $display("FAIL wrap_loads: loads=%0d done=%b want 32 1", load_cnt, done); end
   endtask

   task automatic test_busy_write_restart();
      bit ok;
      int n;
      write_word(5'd0, 16'hD105); // MOV R1,#5
      write_word(5'd1, 16'hE000);
      clear_regs();
      pulse_go();
      n = 0;
      while (s !== 1'b1 && n < 20) begin tick(); n++; end
      while (s !== 1'b0 && n < 40) begin tick(); n++; end
      checks++; if (!(busy === 1'b1 && s === 1'b0 && n < 40))
         begin errors++; $display("FAIL reach_exec: busy=%b s=%b cycles=%0d want 1 0 <40", busy, s, n); end
      write_word(5'd0, 16'hE000); // must be dropped while busy
      wait_done(100, ok);
      checks++; if (!ok || issued !== 8'd1)
         begin errors++; $display("FAIL busy_run: done=%b issued=%0d want 1 1", done, issued); end
      // Writes in DONE are honoured: extend the program by one instruction.
      write_word(5'd1, 16'hD207); // MOV R2,#7
      write_word(5'd2, 16'hE000);
      clear_regs();
      pulse_go();
      checks++; if (issued !== 8'd0 || pc !== 5'd0 || done !== 1'b0 || busy !== 1'b1)
         begin errors++; $display("FAIL restart: issued=%0d pc=%0d done=%b busy=%b want 0 0 0 1", issued, pc, done, busy); end
      wait_done(200, ok);
      checks++; if (!ok || issued !== 8'd2 || pc !== 5'd2)
         begin errors++; $display("FAIL rerun_end: done=%b issued=%0d pc=%0d want 1 2 2", done, issued, pc); end
      checks++; if (regs[1] !== 16'h0005 || regs[2] !== 16'h0007)
         begin errors++; $display("FAIL rerun_regs: r1=%h r2=%h want 0005 0007", regs[1], regs[2]); end
   endtask

   task automatic test_async_reset();
      bit ok;
      int n = 0;
      clear_regs();
      pulse_go();
      while (s !== 1'b1 && n < 20) begin tick(); n++; end
      checks++; if (s !== 1'b1) begin errors++; $display("FAIL reach_start: s=%b want 1", s); end
      reset = 1'b0;
      #1;
      checks++; if ({s, load, busy, done} !== 4'b0000)
         begin errors++; $display("FAIL async_rst: s/load/busy/done=%b want 0000", {s, load, busy, done}); end
      checks++; if (pc !== 5'd0 || issued !== 8'd0)
         begin errors++; $display("FAIL async_rst_regs: pc=%0d issued=%0d want 0 0", pc, issued); end
      tick(2);
      reset = 1'b1;
      tick();
      checks++; if (busy !== 1'b0 || done !== 1'b0)
         begin errors++; $display("FAIL post_rst_idle: busy=%b done=%b want 0 0", busy, done); end
      pulse_go();
      wait_done(200, ok);
      checks++; if (!ok || issued !== 8'd2 || pc !== 5'd2 || in !== 16'hD207)
         begin errors++; $display("FAIL post_rst_run: done=%b issued=%0d pc=%0d in=%h want 1 2 2 D207", done, issued, pc, in); end
      checks++; if (regs[1] !== 16'h0005 || regs[2] !== 16'h0007)
         begin errors++; $display("FAIL post_rst_regs: r1=%h r2=%h want 0005 0007", regs[1], regs[2]); end
   endtask

   initial begin
      clear_regs();
      test_reset();
      test_single_mov();
      test_program();
      test_wrap_end();
      test_busy_write_restart();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cpu_instr_sequencer.md
# cpu_instr_sequencer

Upstream instruction feeder for the `cpu` datapath/controller. Holds a small program in on-chip word memory, walks a program counter, and drives the cpu's `in`/`load`/`s` inputs while obeying its `w` (waiting) handshake, so that a whole program runs without bench-driven stimulus. Execution stops on a HALT word (opcode `111`) or when the program counter passes the last address.

## Interface
- `ADDR_W`, 5: program memory address width; depth = 2**ADDR_W words of 16 bits.
- `HALT_OP`, 3'b111: opcode in bits [15:13] that ends the program.

- `clk` input 1: single clock, all state updates on rising edge.
- `reset` input 1: asynchronous, active-low; clears all state immediately.
- `prog_we` input 1: program write strobe; honoured only in IDLE or DONE.
- `prog_addr` input ADDR_W: program write address.
- `prog_data` input 16: program write data.
- `go` input 1: start request; sampled in IDLE or DONE.
- `w` input 1: cpu waiting flag, from cpu.
- `in` output 16: instruction to cpu, registered.
- `load` output 1: cpu instruction-register load strobe, registered.
- `s` output 1: cpu start strobe, registered.
- `pc` output ADDR_W: address of the instruction being fetched or executed.
- `busy` output 1: high in every state except IDLE and DONE.
- `done` output 1: high in DONE.
- `issued` output 8: count of instructions issued since the last `go`, saturating at 255.

## Operation
- States: IDLE, FETCH, LOAD, START, EXEC, DONE.
- IDLE: `busy=0`, `done=0`. `prog_we=1` writes `prog_data` to `mem[prog_addr]` at the edge. `go=1` moves to FETCH with `pc=0` and `issued=0`. If `go` and `prog_we` are both high, the write occurs and the start also occurs.
- FETCH: synchronous read of `mem[pc]`; data is valid in LOAD.
- LOAD: if `mem[pc][15:13]==HALT_OP`, go to DONE with `load=0`, `in` unchanged, and `issued` unchanged. Otherwise `in<=mem[pc]`, `load=1` for exactly this state, and the next state is START.
- START: `s=1`, `load=0`; remain until `w==0` is sampled (cpu has left its wait state), then go to EXEC and increment `issued` (saturating).
- EXEC: `s=0`; remain until `w==1` is sampled. Then:
  - if `pc==2**ADDR_W-1`, go to DONE with `pc` held;
  - else `pc<=pc+1`, go to FETCH.
- DONE: `done=1`, `busy=0`, `pc`/`in`/`issued` held for inspection. `prog_we` is honoured. `go=1` restarts exactly as from IDLE (`pc=0`, `issued=0`).
- `w` is ignored in IDLE, FETCH, LOAD and DONE.
- `prog_we` in a busy state is dropped; memory is unchanged.
- Memory contents are not cleared by reset; all registers are.

## Timing
- Reset values (asserted asynchronously while `reset=0`): state IDLE, `pc=0`, `in=16'h0000`, `load=0`, `s=0`, `busy=0`, `done=0`, `issued=0`.
- Reset mid-program drops `s`/`load` at once. The cpu must be reset alongside it, since the cpu is also reset by the same system reset.
- `go` sampled high at edge k gives FETCH in cycle k+1, LOAD (`load=1`, `in` valid) in k+2, and START (`s=1`) in k+3.
- `in` changes only on the LOAD edge and is stable through START and EXEC.
- Minimum per-instruction period: FETCH + LOAD + START(1) + EXEC(1) = 4 cycles; it stretches with cpu execution latency.
- `s` is asserted no earlier than the cycle after `load`, so the cpu has latched the instruction before it starts.
- HALT detection costs two cycles after the previous instruction's EXEC exits (FETCH, LOAD), then DONE.
- `issued` saturates: at 255 it holds; it never wraps.

## Test plan
- Reset/idle: hold `reset=0`, toggle `clk` → all outputs at reset values; release reset, no `go` → stays IDLE, `in=0`, `load=0`, `s=0`.
- Single MOV: write `mem[0]=16'b110_10_000_00000011`, `mem[1]=16'hE000`, pulse `go`, drive cpu model (`w` drops one cycle after `s`, returns 3 cycles later) → `load` pulses once with `in=16'hD003`, `s` asserted until `w=0`, then `done=1`, `issued=1`, `pc=1`.
- Full program against real `cpu`: MOV R0,#3; MOV R1,#4; ADD R4,R0,R1; CMP R0,R1; MVN R6,R0; HALT → cpu R4=7, R6=16'hFFFC, N=1, Z=0, V=0 after CMP, `issued=5`, `done=1`.
- Wrap end: fill all 32 words with MOV R0,#1 (no HALT) → `issued=32`, `done=1`, `pc=31`, no 33rd `load` pulse.
- Busy write and restart: assert `prog_we` to `mem[0]` during EXEC → memory unchanged; `go` in DONE → rerun from `pc=0` with `issued` restarting at 0.
- Async reset during START (`s=1`) → `s`, `load`, `busy` go low within the same cycle without a clock edge; state IDLE; after release, program memory is intact and `go` reruns it correctly.
